// File: rtl/ysyx_25040129_wbu_if.sv
// Upstream LSU/EXU -> WBU completed-instruction bundle.
// Master drives the result; slave answers with in_ready.
interface ysyx_25040129_wbu_if #(
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic              in_wen;
  logic              in_is_load;
  logic [1:0]        in_ld_size;
  logic              in_ld_sign;
  logic [1:0]        in_addr_lo;
  logic [31:0]       in_alu_result;
  logic [31:0]       in_mem_rdata;
  logic [31:0]       in_pc;

  modport master (
    output in_valid, in_rd, in_wen,
    output in_is_load, in_ld_size,
    output in_ld_sign, in_addr_lo,
    output in_alu_result, in_mem_rdata,
    output in_pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_wen,
    input  in_is_load, in_ld_size,
    input  in_ld_sign, in_addr_lo,
    input  in_alu_result, in_mem_rdata,
    input  in_pc,
    output in_ready
  );
endinterface

// File: rtl/ysyx_25040129_wbu.sv
// RV32E writeback stage: load align/extend, regfile write,
// and per-register in-flight writer scoreboard for decode.
module ysyx_25040129_wbu #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_25040129_wbu_if.slave up,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_wen,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] src1_id,
  input  logic [REG_AW-1:0] src2_id,
  output logic              hazard,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic [31:0]       result,
  output logic              commit_valid,
  output logic [31:0]       commit_pc,
  output logic              misalign_err
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             accept;
  logic             err;
  logic             wr_dec;
  logic             iss_inc;
  logic [7:0]       byte_l;
  logic [15:0]      half_l;
  logic [31:0]      ld_data;
  logic [31:0]      sel;
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;
  logic [CNT_W-1:0] cnt [NREG];

  assign up.in_ready = rst;
  assign accept = up.in_valid && up.in_ready;

  always_comb begin
    byte_l  = up.in_mem_rdata[7:0];
    half_l  = up.in_mem_rdata[15:0];
    ld_data = up.in_mem_rdata;
    case (up.in_addr_lo)
      2'd1:    byte_l = up.in_mem_rdata[15:8];
      2'd2:    byte_l = up.in_mem_rdata[23:16];
      2'd3:    byte_l = up.in_mem_rdata[31:24];
      default: byte_l = up.in_mem_rdata[7:0];
    endcase
    if (up.in_addr_lo[1])
      half_l = up.in_mem_rdata[31:16];
    case (up.in_ld_size)
      2'b00: ld_data = {
        {24{up.in_ld_sign & byte_l[7]}}, byte_l};
      2'b01: ld_data = {
        {16{up.in_ld_sign & half_l[15]}}, half_l};
      default: ld_data = up.in_mem_rdata;
    endcase
  end

  assign err = up.in_is_load && (
    (up.in_ld_size == 2'b11) ||
    (up.in_ld_size == 2'b01 && up.in_addr_lo[0]) ||
    (up.in_ld_size == 2'b10 && up.in_addr_lo != 2'b00));

  assign sel = up.in_is_load ? ld_data
                             : up.in_alu_result;

  assign wr_dec = accept && up.in_wen &&
                  up.in_rd != '0;
  assign issue_ready = !(issue_wen && issue_rd != '0 &&
                         cnt[issue_rd] == CMAX);
  assign iss_inc = issue_valid && issue_ready &&
                   issue_wen && issue_rd != '0;

  // Conservative: a same-cycle retire is not forwarded.
  assign hazard =
    (src1_id != '0 && cnt[src1_id] != '0) ||
    (src2_id != '0 && cnt[src2_id] != '0);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    inc_v[issue_rd] = iss_inc;
    dec_v[up.in_rd] = wr_dec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_v[r] && !dec_v[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_v[r] && !inc_v[r] &&
                 cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd           <= '0;
      reg_write    <= 1'b0;
      result       <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      misalign_err <= 1'b0;
    end else begin
      reg_write    <= 1'b0;
      commit_valid <= 1'b0;
      misalign_err <= 1'b0;
      if (accept) begin
        rd           <= up.in_rd;
        result       <= sel;
        commit_pc    <= up.in_pc;
        commit_valid <= 1'b1;
        misalign_err <= err;
        reg_write    <= up.in_wen &&
                        up.in_rd != '0 && !err;
      end
    end
  end

  // A retire with no recorded writer is an upstream bug.
  dec_at_zero: assert property (
    @(posedge clk) disable iff (!rst)
    wr_dec |-> cnt[up.in_rd] != '0);

endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// Self-checking bench for ysyx_25040129_wbu against a
// behavioural writeback/scoreboard model.
module tb_ysyx_25040129_wbu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040129_wbu_if #(.REG_AW(4)) bus ();

  logic        issue_valid = 1'b0;
  logic [3:0]  issue_rd = '0;
  logic        issue_wen = 1'b0;
  logic        issue_ready;
  logic [3:0]  src1_id = '0;
  logic [3:0]  src2_id = '0;
  logic        hazard;
  logic [3:0]  rd;
  logic        reg_write;
  logic [31:0] result;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        misalign_err;

  ysyx_25040129_wbu #(.REG_AW(4), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .up           (bus),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_wen    (issue_wen),
    .issue_ready  (issue_ready),
    .src1_id      (src1_id),
    .src2_id      (src2_id),
    .hazard       (hazard),
    .rd           (rd),
    .reg_write    (reg_write),
    .result       (result),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [3:0]  rd;
    bit          wen;
    bit          ld;
    logic [1:0]  sz;
    bit          sg;
    logic [1:0]  a;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
  } txn_t;

  int checks = 0;
  int failures = 0;

  int          cnt_m [16];
  bit          e_rw, e_cv, e_err;
  logic [3:0]  e_rd;
  logic [31:0] e_res, e_pc;
  txn_t        idle;

  function automatic txn_t mk(
    input logic [3:0] r, input bit w, input bit l,
    input logic [1:0] s, input bit g,
    input logic [1:0] a, input logic [31:0] alu,
    input logic [31:0] mem, input logic [31:0] pc);
    txn_t t;
    t.rd = r; t.wen = w; t.ld = l; t.sz = s;
    t.sg = g; t.a = a; t.alu = alu; t.mem = mem;
    t.pc = pc;
    return t;
  endfunction

  function automatic bit errf(input txn_t t);
    return t.ld && (t.sz == 3 ||
      (t.sz == 1 && t.a % 2 == 1) ||
      (t.sz == 2 && t.a != 0));
  endfunction

  function automatic logic [31:0] loadf(input txn_t t);
    logic [31:0] v;
    if (t.sz == 0) begin
      v = (t.mem >> (8 * t.a)) & 32'hFF;
      if (t.sg && v >= 32'h80) v = v - 32'h100;
    end else if (t.sz == 1) begin
      v = (t.mem >> (16 * (t.a / 2))) & 32'hFFFF;
      if (t.sg && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = t.mem;
    end
    return v;
  endfunction

  function automatic bit ready_m(
    input bit w, input logic [3:0] r);
    return !(w && r != 0 && cnt_m[r] >= 3);
  endfunction

  function automatic bit haz_m(
    input logic [3:0] a, input logic [3:0] b);
    return (a != 0 && cnt_m[a] != 0) ||
           (b != 0 && cnt_m[b] != 0);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
    e_rw = 0; e_cv = 0; e_err = 0;
    e_rd = '0; e_res = '0; e_pc = '0;
  endtask

  task automatic tick(input bit v, input txn_t t,
    input bit iv, input bit iw, input logic [3:0] ir);
    bit fire, dec;
    bus.in_valid      = v;
    bus.in_rd         = t.rd;
    bus.in_wen        = t.wen;
    bus.in_is_load    = t.ld;
    bus.in_ld_size    = t.sz;
    bus.in_ld_sign    = t.sg;
    bus.in_addr_lo    = t.a;
    bus.in_alu_result = t.alu;
    bus.in_mem_rdata  = t.mem;
    bus.in_pc         = t.pc;
    issue_valid = iv;
    issue_wen   = iw;
    issue_rd    = ir;
    fire = iv && iw && ir != 0 && ready_m(iw, ir);
    dec  = v && t.wen && t.rd != 0;
    if (fire && !(dec && t.rd == ir)) cnt_m[ir]++;
    if (dec && !(fire && t.rd == ir) && cnt_m[t.rd] > 0)
      cnt_m[t.rd]--;
    e_cv  = v;
    e_err = v && errf(t);
    e_rw  = dec && !errf(t);
    if (v) begin
      e_rd  = t.rd;
      e_pc  = t.pc;
      e_res = t.ld ? loadf(t) : t.alu;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    issue_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(1, mk(5, 1, 0, 0, 0, 0, 32'h1234, 0, 32'h44),
         1, 1, 4);
    bus.in_valid = 1'b1;
    issue_valid  = 1'b1;
    src1_id = 4;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_model();
    checks++;
    if (reg_write !== 1'b0 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_out rw=%b cv=%b req 0 0",
               reg_write, commit_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got %b req 0", bus.in_ready);
    end
    checks++;
    if (rd !== 4'd0 || result !== 32'd0 ||
        commit_pc !== 32'd0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_regs rd=%h res=%h pc=%h me=%b req 0",
               rd, result, commit_pc, misalign_err);
    end
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL rst_cnt hazard=%b req 0", hazard);
    end
    bus.in_valid = 1'b0;
    issue_valid  = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rel_ready got %b req 1", bus.in_ready);
    end
    tick(0, idle, 0, 0, 0);
    checks++;
    if (reg_write !== 1'b0 || commit_valid !== 1'b0 ||
        hazard !== 1'b0) begin
      failures++;
      $display("FAIL rel_idle rw=%b cv=%b hz=%b req 0 0 0",
               reg_write, commit_valid, hazard);
    end
  endtask

  task automatic test_alu();
    tick(0, idle, 1, 1, 5);
    src1_id = 5; #1;
    checks++;
    if (hazard !== haz_m(5, 0)) begin
      failures++;
      $display("FAIL alu_haz got %b req %b",
               hazard, haz_m(5, 0));
    end
    tick(1, mk(5, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0,
               32'h80000000), 0, 0, 0);
    checks++;
    if (reg_write !== 1'b1 || rd !== 4'd5 ||
        commit_valid !== 1'b1) begin
      failures++;
      $display("FAIL alu_wr rw=%b rd=%0d cv=%b req 1 5 1",
               reg_write, rd, commit_valid);
    end
    checks++;
    if (result !== 32'hDEADBEEF ||
        commit_pc !== 32'h80000000) begin
      failures++;
      $display("FAIL alu_res res=%h pc=%h req deadbeef 80000000",
               result, commit_pc);
    end
    tick(0, idle, 0, 0, 0);
    checks++;
    if (reg_write !== 1'b0 || commit_valid !== 1'b0 ||
        rd !== 4'd5 || result !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_idle rw=%b cv=%b rd=%0d res=%h",
               reg_write, commit_valid, rd, result);
    end
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL alu_clr hazard=%b req 0", hazard);
    end
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz [5] = '{0, 0, 1, 1, 2};
    bit          sg [5] = '{1, 0, 1, 0, 1};
    logic [1:0]  ad [5] = '{0, 2, 2, 0, 0};
    logic [31:0] ex [5] = '{32'hFFFFFF82, 32'h000000F1,
                            32'hFFFF80F1, 32'h00007F82,
                            32'h80F17F82};
    for (int i = 0; i < 5; i++) begin
      tick(0, idle, 1, 1, 9);
      tick(1, mk(9, 1, 1, sz[i], sg[i], ad[i], 0,
                 32'h80F17F82, 32'h100 + i), 0, 0, 0);
      checks++;
      if (result !== ex[i] || reg_write !== 1'b1) begin
        failures++;
        $display("FAIL ld%0d res=%h rw=%b req %h 1",
                 i, result, reg_write, ex[i]);
      end
    end
  endtask

  task automatic test_misalign();
    tick(0, idle, 1, 1, 3);
    tick(1, mk(3, 1, 1, 1, 1, 1, 0, 32'h80F17F82,
               32'h200), 0, 0, 0);
    checks++;
    if (misalign_err !== 1'b1 || commit_valid !== 1'b1 ||
        reg_write !== 1'b0) begin
      failures++;
      $display("FAIL mis me=%b cv=%b rw=%b req 1 1 0",
               misalign_err, commit_valid, reg_write);
    end
    src1_id = 3; #1;
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL mis_dec hazard=%b req 0", hazard);
    end
    tick(0, idle, 0, 0, 0);
    checks++;
    if (misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL mis_pulse me=%b req 0", misalign_err);
    end
  endtask

  task automatic test_scoreboard();
    txn_t w7;
    w7 = mk(7, 1, 0, 0, 0, 0, 32'h77, 0, 32'h300);
    repeat (3) tick(0, idle, 1, 1, 7);
    issue_wen = 1; issue_rd = 7; src1_id = 7; #1;
    checks++;
    if (issue_ready !== 1'b0 || hazard !== 1'b1) begin
      failures++;
      $display("FAIL sb_full ir=%b hz=%b req 0 1",
               issue_ready, hazard);
    end
    tick(1, w7, 1, 1, 7);
    tick(1, w7, 1, 1, 7);
    checks++;
    if (issue_ready !== ready_m(1, 7) ||
        hazard !== haz_m(7, 0)) begin
      failures++;
      $display("FAIL sb_same ir=%b hz=%b req %b %b",
               issue_ready, hazard, ready_m(1, 7),
               haz_m(7, 0));
    end
    tick(1, w7, 0, 0, 0);
    checks++;
    if (hazard !== haz_m(7, 0)) begin
      failures++;
      $display("FAIL sb_one hz=%b req %b",
               hazard, haz_m(7, 0));
    end
    tick(1, w7, 0, 0, 0);
    checks++;
    if (hazard !== 1'b0 || cnt_m[7] != 0) begin
      failures++;
      $display("FAIL sb_drain hz=%b req 0", hazard);
    end
  endtask

  task automatic test_x0();
    issue_wen = 1; issue_rd = 0; #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready got %b req 1", issue_ready);
    end
    tick(0, idle, 1, 1, 0);
    tick(1, mk(0, 1, 0, 0, 0, 0, 32'h55, 0, 32'h400),
         0, 0, 0);
    src1_id = 0; src2_id = 0; #1;
    checks++;
    if (reg_write !== 1'b0 || commit_valid !== 1'b1 ||
        hazard !== 1'b0) begin
      failures++;
      $display("FAIL x0 rw=%b cv=%b hz=%b req 0 1 0",
               reg_write, commit_valid, hazard);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, idle, 1, 1, 6);
    bus.in_valid = 1; bus.in_rd = 6; bus.in_wen = 1;
    bus.in_is_load = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 0;
    reset_model();
    src1_id = 6; #1;
    checks++;
    if (reg_write !== 1'b0 || commit_valid !== 1'b0 ||
        hazard !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid rw=%b cv=%b hz=%b req 0 0 0",
               reg_write, commit_valid, hazard);
    end
    tick(0, idle, 0, 0, 0);
    checks++;
    if (reg_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid2 rw=%b req 0", reg_write);
    end
  endtask

  task automatic test_random();
    txn_t t;
    bit v, iv, iw;
    logic [3:0] ir, c, s1, s2;
    for (int n = 0; n < 300; n++) begin
      v = 1'($urandom_range(0, 1));
      c = 4'($urandom_range(1, 15));
      t = mk(0, 0, 1'($urandom_range(0, 1)),
             2'($urandom), 1'($urandom), 2'($urandom),
             $urandom, $urandom, $urandom);
      if (cnt_m[c] > 0) begin
        t.rd = c; t.wen = 1;
      end else begin
        t.wen = 1'($urandom_range(0, 1));
        t.rd = t.wen ? 4'd0 : c;
      end
      iv = 1'($urandom_range(0, 1));
      iw = 1'($urandom_range(0, 3) != 0);
      ir = 4'($urandom);
      tick(v, t, iv, iw, ir);
      checks++;
      if (commit_valid !== e_cv || reg_write !== e_rw ||
          misalign_err !== e_err) begin
        failures++;
        $display("FAIL rnd%0d cv=%b rw=%b me=%b req %b %b %b",
                 n, commit_valid, reg_write, misalign_err,
                 e_cv, e_rw, e_err);
      end
      checks++;
      if (rd !== e_rd || commit_pc !== e_pc) begin
        failures++;
        $display("FAIL rnd%0d_rd rd=%h pc=%h req %h %h",
                 n, rd, commit_pc, e_rd, e_pc);
      end
      if (v && !e_err) begin
        checks++;
        if (result !== e_res) begin
          failures++;
          $display("FAIL rnd%0d_res got %h req %h",
                   n, result, e_res);
        end
      end
      s1 = 4'($urandom); s2 = 4'($urandom);
      src1_id = s1; src2_id = s2;
      issue_wen = 1'($urandom_range(0, 1));
      issue_rd = 4'($urandom);
      #1;
      checks++;
      if (hazard !== haz_m(s1, s2) ||
          issue_ready !== ready_m(issue_wen, issue_rd)) begin
        failures++;
        $display("FAIL rnd%0d_sb hz=%b ir=%b req %b %b",
                 n, hazard, issue_ready, haz_m(s1, s2),
                 ready_m(issue_wen, issue_rd));
      end
    end
  endtask

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_model();
    bus.in_valid = 0; bus.in_rd = 0; bus.in_wen = 0;
    bus.in_is_load = 0; bus.in_ld_size = 0;
    bus.in_ld_sign = 0; bus.in_addr_lo = 0;
    bus.in_alu_result = 0; bus.in_mem_rdata = 0;
    bus.in_pc = 0;
    test_reset();
    test_alu();
    test_load_ext();
    test_misalign();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
